id_ex_pipe: RTL
===============

# id_ex_pipe

ID/EX pipeline register for the 16-bit pipelined processor, sitting directly upstream of the execute-stage ALU and driving its A, B, Cin and ALUop inputs. It captures decoded operands and control from decode, and applies EX/MEM and MEM/WB forwarding to the operands it presents to the ALU. It also detects load-use hazards against the instruction it currently holds. Stall holds the stage and flush inserts a bubble.

## Interface
- DW, 16, datapath width; must match ALU A/B width
- RW, 3, register index width (8 architectural registers)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current contents (from hazard unit)
- flush  in  1  replace contents with a bubble (branch/jump redirect)
- id_valid  in  1  decode slot holds a real instruction
- id_a, id_b  in  DW  register-file read data for rs, rt
- id_imm  in  DW  sign/zero-extended immediate
- id_use_imm  in  1  B operand is id_imm instead of id_b
- id_cin  in  1  ALU carry-in (1 for subtract)
- id_aluop  in  4  ALU opcode
- id_rs, id_rt, id_rd  in  RW  source and destination indices
- id_rt_used  in  1  instruction reads rt (register B or store data)
- id_regwrite, id_memread, id_memwrite  in  1  control bits
- exm_regwrite  in  1  EX/MEM instruction writes a register
- exm_rd  in  RW  EX/MEM destination
- exm_data  in  DW  EX/MEM ALU result
- mwb_regwrite  in  1  MEM/WB instruction writes a register
- mwb_rd  in  RW  MEM/WB destination
- mwb_data  in  DW  MEM/WB writeback value
- ex_valid  out  1  EX slot holds a real instruction
- ex_A, ex_B  out  DW  forwarded ALU operands
- ex_Cin  out  1  ALU carry-in
- ex_ALUop  out  4  ALU opcode
- ex_store_data  out  DW  forwarded rt value for stores
- ex_rd  out  RW  destination index
- ex_regwrite, ex_memread, ex_memwrite  out  1  control, forced 0 when ex_valid=0
- load_use  out  1  combinational; decode must stall next edge

## Operation
- Registered state: valid, a, b, imm, use_imm, cin, aluop, rs, rt, rd, rt_used, regwrite, memread, memwrite.
- Edge priority: rst > flush > stall > load.
  - rst or flush: valid=0, all control bits 0, aluop=0, cin=0, data and indices 0.
  - stall: all fields hold, except a and b, which reload from the forwarded values (fwd_a, fwd_b). A producer that retires during the stall is therefore not lost.
  - load: every field takes its id_* counterpart.
- Forwarding for A (rs), evaluated combinationally every cycle:
  - If exm_regwrite and exm_rd==rs: use exm_data.
  - Else if mwb_regwrite and mwb_rd==rs: use mwb_data.
  - Else: use registered a.
  - EX/MEM has priority over MEM/WB.
- Forwarding for rt is identical, giving fwd_b. Register 0 gets no special treatment.
- ex_A = fwd_a.
- ex_B = use_imm ? imm : fwd_b.
- ex_store_data = fwd_b.
- ex_regwrite, ex_memread, ex_memwrite are the registered bits ANDed with valid.
- load_use = valid & memread & regwrite & (id_valid & ((id_rs==rd) | (id_rt_used & id_rt==rd))).
- No arithmetic is performed here; widths pass through unchanged.

## Timing
- Latency: one cycle from id_* to ex_* for a load edge.
- Forwarding is zero-cycle combinational: exm/mwb changes reach ex_A/ex_B in the same cycle.
- Reset value of every output, given exm_regwrite=mwb_regwrite=0:
  - ex_valid=0, ex_A=0, ex_B=0, ex_Cin=0, ex_ALUop=0, ex_store_data=0, ex_rd=0
  - ex_regwrite=ex_memread=ex_memwrite=0, load_use=0
- Simultaneous events:
  - flush with stall: flush wins and a bubble is inserted.
  - rst mid-stall: bubble at the next edge.
- load_use is asserted in the same cycle as the hazard. It is deasserted the cycle after the hazard unit holds decode, because the next edge loads the consumer into a bubble-preceded slot; that bubble is produced externally via flush.

## Configuration
- ID_EX_FWD_EN defined: forwarding muxes and stall-time operand refresh present as described.
- ID_EX_FWD_EN undefined:
  - fwd_a=a and fwd_b=b always; exm_*/mwb_* inputs are ignored.
  - stall holds a and b unchanged.
  - load_use still operates.
  - The hazard unit is responsible for stalling on all RAW hazards.

## Test plan
- Reset: rst=1 with any inputs for one edge -> ex_valid=0, all ex_* outputs 0, load_use=0.
- Load and pass-through: id_a=0x1234, id_imm=0x0005, id_use_imm=1, id_aluop=4'b0000, id_cin=0, id_valid=1 -> next cycle ex_A=0x1234, ex_B=0x0005, ex_ALUop=0.
- Forwarding priority: registered rs=3, a=0x0001; exm_regwrite=1, exm_rd=3, exm_data=0xAAAA; mwb_regwrite=1, mwb_rd=3, mwb_data=0x5555 -> ex_A=0xAAAA. Drop exm_regwrite -> ex_A=0x5555.
- Stall refresh: stall=1; cycle 1 mwb_rd=rt=2, mwb_data=0x00FF; cycle 2 mwb_regwrite=0 -> ex_B stays 0x00FF in cycle 2. Without ID_EX_FWD_EN, ex_B keeps the original id_b.
- Flush over stall: stall=1 and flush=1 together on a valid store -> next cycle ex_valid=0, ex_memwrite=0, ex_regwrite=0.
- Load-use: EX holds a load with rd=4; decode presents id_rt=4, id_rt_used=1 -> load_use=1. With id_rt_used=0 and id_rs=1 -> load_use=0.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: decode-to-execute bundle for the ID/EX pipeline register
// Signals: stall/flush from the hazard unit, id_* decoded fields, exm_*/mwb_*
// forwarding sources, ex_* operands/control to the ALU, load_use hazard flag.
// master drives decode/forwarding/hazard inputs; slave is the pipeline register.
interface id_ex_pipe_if #(parameter int DW = 16, parameter int RW = 3);
   logic          stall, flush;
   logic          id_valid;
   logic [DW-1:0] id_a, id_b, id_imm;
   logic          id_use_imm, id_cin;
   logic [3:0]    id_aluop;
   logic [RW-1:0] id_rs, id_rt, id_rd;
   logic          id_rt_used, id_regwrite, id_memread, id_memwrite;
   logic          exm_regwrite;
   logic [RW-1:0] exm_rd;
   logic [DW-1:0] exm_data;
   logic          mwb_regwrite;
   logic [RW-1:0] mwb_rd;
   logic [DW-1:0] mwb_data;
   logic          ex_valid;
   logic [DW-1:0] ex_A, ex_B, ex_store_data;
   logic          ex_Cin;
   logic [3:0]    ex_ALUop;
   logic [RW-1:0] ex_rd;
   logic          ex_regwrite, ex_memread, ex_memwrite;
   logic          load_use;
   modport master (
      output stall, flush, id_valid, id_a, id_b, id_imm, id_use_imm, id_cin, id_aluop,
             id_rs, id_rt, id_rd, id_rt_used, id_regwrite, id_memread, id_memwrite,
             exm_regwrite, exm_rd, exm_data, mwb_regwrite, mwb_rd, mwb_data,
      input  ex_valid, ex_A, ex_B, ex_Cin, ex_ALUop, ex_store_data, ex_rd,
             ex_regwrite, ex_memread, ex_memwrite, load_use
   );
   modport slave (
      input  stall, flush, id_valid, id_a, id_b, id_imm, id_use_imm, id_cin, id_aluop,
             id_rs, id_rt, id_rd, id_rt_used, id_regwrite, id_memread, id_memwrite,
             exm_regwrite, exm_rd, exm_data, mwb_regwrite, mwb_rd, mwb_data,
      output ex_valid, ex_A, ex_B, ex_Cin, ex_ALUop, ex_store_data, ex_rd,
             ex_regwrite, ex_memread, ex_memwrite, load_use
   );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with operand forwarding and load-use detection
// Ports: clk, rst (sync, active-high); bus (id_ex_pipe_if.slave) carrying
// stall/flush, decoded id_* fields, exm_*/mwb_* forwarding sources, ex_* ALU
// operands/control and the combinational load_use flag.
// Macro ID_EX_FWD_EN: enables the forwarding muxes and the stall-time operand
// refresh; without it operands come straight from the registered a/b.
module id_ex_pipe #(parameter int DW = 16, parameter int RW = 3) (
   input logic         clk,
   input logic         rst,
   id_ex_pipe_if.slave bus
);
   logic          valid, use_imm, cin, rt_used, regwrite, memread, memwrite;
   logic [DW-1:0] a, b, imm, fwd_a, fwd_b;
   logic [3:0]    aluop;
   logic [RW-1:0] rs, rt, rd;
`ifdef ID_EX_FWD_EN
   assign fwd_a = (bus.exm_regwrite && bus.exm_rd == rs) ? bus.exm_data :
                  (bus.mwb_regwrite && bus.mwb_rd == rs) ? bus.mwb_data : a;
   assign fwd_b = (bus.exm_regwrite && bus.exm_rd == rt) ? bus.exm_data :
                  (bus.mwb_regwrite && bus.mwb_rd == rt) ? bus.mwb_data : b;
`else
   assign fwd_a = a;
   assign fwd_b = b;
`endif
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         valid    <= 1'b0;
         a        <= '0;
         b        <= '0;
         imm      <= '0;
         use_imm  <= 1'b0;
         cin      <= 1'b0;
         aluop    <= '0;
         rs       <= '0;
         rt       <= '0;
         rd       <= '0;
         rt_used  <= 1'b0;
         regwrite <= 1'b0;
         memread  <= 1'b0;
         memwrite <= 1'b0;
      end else if (bus.stall) begin
         // capture producers that retire while held so their value survives
         a <= fwd_a;
         b <= fwd_b;
      end else begin
         valid    <= bus.id_valid;
         a        <= bus.id_a;
         b        <= bus.id_b;
         imm      <= bus.id_imm;
         use_imm  <= bus.id_use_imm;
         cin      <= bus.id_cin;
         aluop    <= bus.id_aluop;
         rs       <= bus.id_rs;
         rt       <= bus.id_rt;
         rd       <= bus.id_rd;
         rt_used  <= bus.id_rt_used;
         regwrite <= bus.id_regwrite;
         memread  <= bus.id_memread;
         memwrite <= bus.id_memwrite;
      end
   end
   assign bus.ex_valid      = valid;
   assign bus.ex_A          = fwd_a;
   assign bus.ex_B          = use_imm ? imm : fwd_b;
   assign bus.ex_Cin        = cin;
   assign bus.ex_ALUop      = aluop;
   assign bus.ex_store_data = fwd_b;
   assign bus.ex_rd         = rd;
   assign bus.ex_regwrite   = regwrite & valid;
   assign bus.ex_memread    = memread & valid;
   assign bus.ex_memwrite   = memwrite & valid;
   assign bus.load_use      = valid & memread & regwrite & bus.id_valid &
                              ((bus.id_rs == rd) | (bus.id_rt_used & (bus.id_rt == rd)));
endmodule
